// File: rtl/video_timing_delay.sv
// Programmable delay line for the pixel timing bundle (DE, hsync, vsync, x, y).
// The delay changes only on a vsync leading edge. DE stays gated until the
// shift chain holds delay_active samples of real history.
module video_timing_delay #(
  parameter int unsigned XW            = 11,
  parameter int unsigned YW            = 11,
  parameter int unsigned MAX_DELAY     = 8,
  parameter int unsigned DEFAULT_DELAY = 5,
  parameter bit          SYNC_ACTIVE   = 1'b1,
  parameter int unsigned CW            = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          de_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [XW-1:0] x_in,
  input  logic [YW-1:0] y_in,
  input  logic [CW-1:0] delay_cfg,
  output logic          de_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [CW-1:0] delay_active,
  output logic          cfg_pending,
  output logic          primed
);

  logic          r_de [1:MAX_DELAY];
  logic          r_hs [1:MAX_DELAY];
  logic          r_vs [1:MAX_DELAY];
  logic [XW-1:0] r_x  [1:MAX_DELAY];
  logic [YW-1:0] r_y  [1:MAX_DELAY];

  logic          r_vs_prev;
  logic [CW-1:0] r_fill_cnt;
  logic [CW-1:0] r_delay_active;

  logic [CW-1:0] w_cfg_c;
  logic          w_vs_edge;
  logic          w_primed;
  logic          w_sel_de;
  logic          w_sel_hs;
  logic          w_sel_vs;
  logic [XW-1:0] w_sel_x;
  logic [YW-1:0] w_sel_y;

  // Clamp the requested delay into 1..MAX_DELAY.
  always_comb begin
    w_cfg_c = delay_cfg;
    if (delay_cfg == '0) begin
      w_cfg_c = CW'(1);
    end else if (delay_cfg > CW'(MAX_DELAY)) begin
      w_cfg_c = CW'(MAX_DELAY);
    end
  end

  // r_vs_prev only holds a real sample once a ce has passed since reset, so a
  // vsync already active at reset release is not taken as a frame edge.
  assign w_vs_edge = ce && (vsync_in == SYNC_ACTIVE) && (r_vs_prev != SYNC_ACTIVE)
                     && (r_fill_cnt != '0);

  assign w_primed = (r_fill_cnt >= r_delay_active);

  // Shift chain, frame-edge tracking, fill counter and applied delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
        r_de[k] <= 1'b0;
        r_hs[k] <= ~SYNC_ACTIVE;
        r_vs[k] <= ~SYNC_ACTIVE;
        r_x[k]  <= '0;
        r_y[k]  <= '0;
      end
      r_vs_prev      <= ~SYNC_ACTIVE;
      r_fill_cnt     <= '0;
      r_delay_active <= CW'(DEFAULT_DELAY);
    end else if (ce) begin
      r_de[1] <= de_in;
      r_hs[1] <= hsync_in;
      r_vs[1] <= vsync_in;
      r_x[1]  <= x_in;
      r_y[1]  <= y_in;
      for (int unsigned k = 2; k <= MAX_DELAY; k++) begin
        r_de[k] <= r_de[k-1];
        r_hs[k] <= r_hs[k-1];
        r_vs[k] <= r_vs[k-1];
        r_x[k]  <= r_x[k-1];
        r_y[k]  <= r_y[k-1];
      end
      r_vs_prev <= vsync_in;
      // Not cleared on a delay change: the stages always hold real history.
      if (r_fill_cnt != CW'(MAX_DELAY)) begin
        r_fill_cnt <= r_fill_cnt + CW'(1);
      end
      if (w_vs_edge) begin
        r_delay_active <= w_cfg_c;
      end
    end
  end

  // Output tap select from the registered stages.
  always_comb begin
    w_sel_de = 1'b0;
    w_sel_hs = ~SYNC_ACTIVE;
    w_sel_vs = ~SYNC_ACTIVE;
    w_sel_x  = '0;
    w_sel_y  = '0;
    for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
      if (r_delay_active == CW'(k)) begin
        w_sel_de = r_de[k];
        w_sel_hs = r_hs[k];
        w_sel_vs = r_vs[k];
        w_sel_x  = r_x[k];
        w_sel_y  = r_y[k];
      end
    end
  end

  assign de_out       = w_sel_de & w_primed;
  assign hsync_out    = w_sel_hs;
  assign vsync_out    = w_sel_vs;
  assign x_out        = w_sel_x;
  assign y_out        = w_sel_y;
  assign delay_active = r_delay_active;
  assign cfg_pending  = (w_cfg_c != r_delay_active);
  assign primed       = w_primed;

endmodule
